bp_dynamic_predictor: RTL and testbench
=======================================

// Module: bp_dynamic_predictor
// PURPOSE
//  Parametrised dynamic branch predictor replacing the static not-taken policy of the 5-stage RV32I pipeline.
//  IF stage: look up if_pc in a direct-mapped BTB and 2-bit BHT; return taken/target in the same cycle.
//  EX stage: resolved br/jal outcome trains the tables, global history and perf counters.
//  Bimodal or gshare indexing, chosen by parameter.
// PARAMETERS
//  BTB_ENTRIES  64  BTB entries (power of 2, >=2)
//  BHT_ENTRIES  256 2-bit counters (power of 2, >=2)
//  GHR_W        8   global history bits (<= log2(BHT_ENTRIES)); ignored in bimodal mode
//  MODE         1   0 = bimodal (index pc[IB+1:2]); 1 = gshare (pc[IB+1:2] ^ ghr)
//  CNT_W        32  perf counter width
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous reset, active high
//  stall        in   1        pipeline stall; freezes all state updates
//  if_pc        in   32       fetch PC
//  if_pred_taken out 1        predict redirect to if_pred_target
//  if_pred_target out 32      predicted target (valid when if_pred_taken)
//  if_bht_idx   out  IB       BHT index used; carried down pipe with instr (IB = log2(BHT_ENTRIES))
//  upd_valid    in   1        EX has a resolved br/jal this cycle
//  upd_is_jal   in   1        resolved instr is jal (always taken)
//  upd_pc       in   32       PC of resolved instr
//  upd_bht_idx  in   IB       if_bht_idx carried with that instr
//  upd_taken    in   1        actual outcome
//  upd_target   in   32       actual taken target
//  upd_mispred  in   1        prediction was wrong (pipe flushes)
//  perf_branches out CNT_W    resolved br/jal count
//  perf_mispred out  CNT_W    misprediction count
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): all BTB valid=0; all BHT counters=2'b01 (weak NT); ghr=0;
//   perf counters=0. Outputs after reset: if_pred_taken=0, if_pred_target=0 (pure functions of state).
//  Lookup (combinational, 0-cycle): bi = pc[TB+1:2], tag = pc[31:TB+2] (TB = log2(BTB_ENTRIES)).
//   hit = valid[bi] && tag match. if_pred_taken = hit && (is_jal[bi] || bht[if_bht_idx][1]).
//   if_pred_target = hit ? target[bi] : 0. jal entries ignore BHT.
//  Index: bimodal if_bht_idx = if_pc[IB+1:2]; gshare = if_pc[IB+1:2] ^ {zero-pad, ghr}.
//  Update (posedge, when upd_valid && !stall && !rst):
//   - BHT[upd_bht_idx]: saturating +1 if taken, -1 if not; clamps at 3/0; skipped for jal.
//   - BTB[upd_pc]: if taken, write valid=1, tag, target=upd_target, is_jal; not-taken leaves entry.
//   - ghr <= {ghr[GHR_W-2:0], upd_taken} for conditional branches only (non-speculative history).
//   - perf_branches += 1; perf_mispred += upd_mispred. Both wrap modulo 2^CNT_W.
//  stall=1: no table, ghr or counter writes; lookup still combinational.
//  Same-entry read/write in one cycle: lookup returns pre-write value (no bypass).
//  rst concurrent with upd_valid: reset wins, update dropped.
//  Entries conflict-evict silently (direct-mapped, last writer wins).
// STRUCTURE
//  Shared package rv32i_types: bp_mode_e {BP_BIMODAL, BP_GSHARE};
//   rv32i_bp_word struct {pred_taken, pred_target, bht_idx} carried through IF/ID and ID/EX.
//  Sub-module bp_counter_table: parametrised array of 2-bit saturating counters, 1 comb read port,
//   1 sync write port, sync reset to 2'b01.
//  BTB, ghr and perf counters live in this module as flop arrays.
// TESTING
//  1 Reset then if_pc=0x60 -> pred_taken=0, target=0, perf counters 0.
//  2 MODE=0: bne @0x100 taken to 0x80, upd x2 -> next lookup 0x100 taken=1, target=0x80;
//    one not-taken update -> still taken (cnt 2); second -> not taken.
//  3 jal @0x200 -> 0x400 resolved once -> lookup 0x200 taken=1, target 0x400 regardless of BHT.
//  4 MODE=1, GHR_W=4: alternating T/NT loop at 0x300, 20 iters -> mispred count stops growing after warm-up.
//  5 upd_valid with stall=1 -> no state change; 0x100 and 0x100+4*BTB_ENTRIES alias -> second evicts first.
//  6 CNT_W=4: 17 resolved branches -> perf_branches=1 (wrap); rst with upd_valid -> all state reset.

Source files
------------

// File: rtl/bp_dynamic_predictor_pkg.sv
// Shared branch-predictor types: indexing mode, per-instruction prediction word
// carried down the pipe, and the 2-bit saturating counter step.
package bp_dynamic_predictor_pkg;

    typedef enum logic {
        BP_BIMODAL = 1'b0,
        BP_GSHARE  = 1'b1
    } bp_mode_e;

    localparam int unsigned BP_IDX_W    = 8;
    localparam logic [1:0]  CNT_WEAK_NT = 2'b01;

    typedef struct packed {
        logic                pred_taken;
        logic [31:0]         pred_target;
        logic [BP_IDX_W-1:0] bht_idx;
    } rv32i_bp_word;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken && cnt != 2'b11) begin
            nxt = cnt + 2'd1;
        end else if (!taken && cnt != 2'b00) begin
            nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_dynamic_predictor_counter_table.sv
// Array of 2-bit saturating counters: one combinational read port, one
// synchronous training port, synchronous reset to weakly not-taken.
module bp_counter_table
    import bp_dynamic_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 256,
    localparam int unsigned IW     = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] rd_idx,
    output logic [1:0]    rd_cnt_c,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_idx,
    input  logic          wr_taken
);

    logic [1:0] cnt [ENTRIES];

    assign rd_cnt_c = cnt[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                cnt[i] <= CNT_WEAK_NT;
            end
        end else if (wr_en) begin
            cnt[wr_idx] <= sat_update(cnt[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/bp_dynamic_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus 2-bit BHT (bimodal or gshare),
// 0-cycle lookup in IF, non-speculative training from resolved EX outcomes.
module bp_dynamic_predictor
    import bp_dynamic_predictor_pkg::*;
#(
    parameter int unsigned BTB_ENTRIES = 64,
    parameter int unsigned BHT_ENTRIES = 256,
    parameter int unsigned GHR_W       = 8,
    parameter int unsigned MODE        = 1,
    parameter int unsigned CNT_W       = 32,
    localparam int unsigned IB         = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    output logic [31:0]      if_pred_target,
    output logic [IB-1:0]    if_bht_idx,
    input  logic             upd_valid,
    input  logic             upd_is_jal,
    input  logic [31:0]      upd_pc,
    input  logic [IB-1:0]    upd_bht_idx,
    input  logic             upd_taken,
    input  logic [31:0]      upd_target,
    input  logic             upd_mispred,
    output logic [CNT_W-1:0] perf_branches,
    output logic [CNT_W-1:0] perf_mispred
);

    localparam int unsigned TB    = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = 30 - TB;

    logic             btb_valid  [BTB_ENTRIES];
    logic             btb_is_jal [BTB_ENTRIES];
    logic [TAG_W-1:0] btb_tag    [BTB_ENTRIES];
    logic [31:0]      btb_target [BTB_ENTRIES];
    logic [GHR_W-1:0] ghr;

    logic [TB-1:0]    rd_bi;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic [1:0]       bht_cnt;
    logic [TB-1:0]    wr_bi;
    logic             do_update;
    logic             pc_lsb_unused;

    assign pc_lsb_unused = ^{if_pc[1:0], upd_pc[1:0], bht_cnt[0]};

    assign do_update = upd_valid && !stall;

    // History is folded in only for gshare; bimodal uses the raw PC slice.
    always_comb begin
        if_bht_idx = if_pc[IB+1:2];
        if (MODE == 32'(BP_GSHARE)) begin
            if_bht_idx = if_pc[IB+1:2] ^ IB'(ghr);
        end
    end

    assign rd_bi  = if_pc[TB+1:2];
    assign rd_tag = if_pc[31:TB+2];
    assign rd_hit = btb_valid[rd_bi] && (btb_tag[rd_bi] == rd_tag);

    assign if_pred_taken  = rd_hit && (btb_is_jal[rd_bi] || bht_cnt[1]);
    assign if_pred_target = rd_hit ? btb_target[rd_bi] : 32'd0;

    bp_counter_table #(
        .ENTRIES (BHT_ENTRIES)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (if_bht_idx),
        .rd_cnt_c (bht_cnt),
        .wr_en    (do_update && !upd_is_jal),
        .wr_idx   (upd_bht_idx),
        .wr_taken (upd_taken)
    );

    assign wr_bi = upd_pc[TB+1:2];

    // BTB: only taken outcomes allocate; the last writer of an index wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                btb_valid[i] <= 1'b0;
            end
        end else if (do_update && upd_taken) begin
            btb_valid[wr_bi]  <= 1'b1;
            btb_is_jal[wr_bi] <= upd_is_jal;
            btb_tag[wr_bi]    <= upd_pc[31:TB+2];
            btb_target[wr_bi] <= upd_target;
        end
    end

    // Global history tracks conditional branches only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (do_update && !upd_is_jal) begin
            ghr <= GHR_W'({ghr, upd_taken});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_branches <= '0;
            perf_mispred  <= '0;
        end else if (do_update) begin
            perf_branches <= perf_branches + CNT_W'(1);
            perf_mispred  <= perf_mispred + CNT_W'(upd_mispred);
        end
    end

endmodule

// File: tb/tb_bp_dynamic_predictor.sv
// Directed bench: a bimodal instance (4-bit perf counters) and a gshare instance
// (4-bit history) share the fetch/resolve stimulus.
module tb_bp_dynamic_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic        upd_is_jal;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [7:0]  upd_bht_idx_b, upd_bht_idx_g;
    logic        upd_mispred_b, upd_mispred_g;

    logic        b_taken, g_taken;
    logic [31:0] b_target, g_target;
    logic [7:0]  b_idx, g_idx;
    logic [3:0]  b_br, b_mp;
    logic [31:0] g_br, g_mp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bp_dynamic_predictor #(
        .BTB_ENTRIES (64), .BHT_ENTRIES (256), .GHR_W (8), .MODE (0), .CNT_W (4)
    ) u_bim (
        .clk (clk), .rst (rst), .stall (stall), .if_pc (if_pc),
        .if_pred_taken (b_taken), .if_pred_target (b_target), .if_bht_idx (b_idx),
        .upd_valid (upd_valid), .upd_is_jal (upd_is_jal), .upd_pc (upd_pc),
        .upd_bht_idx (upd_bht_idx_b), .upd_taken (upd_taken), .upd_target (upd_target),
        .upd_mispred (upd_mispred_b), .perf_branches (b_br), .perf_mispred (b_mp)
    );

    bp_dynamic_predictor #(
        .BTB_ENTRIES (64), .BHT_ENTRIES (256), .GHR_W (4), .MODE (1), .CNT_W (32)
    ) u_gsh (
        .clk (clk), .rst (rst), .stall (stall), .if_pc (if_pc),
        .if_pred_taken (g_taken), .if_pred_target (g_target), .if_bht_idx (g_idx),
        .upd_valid (upd_valid), .upd_is_jal (upd_is_jal), .upd_pc (upd_pc),
        .upd_bht_idx (upd_bht_idx_g), .upd_taken (upd_taken), .upd_target (upd_target),
        .upd_mispred (upd_mispred_g), .perf_branches (g_br), .perf_mispred (g_mp)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        @(negedge clk);
        if_pc = pc;
        #1;
    endtask

    // Fetch-time lookup feeds the carried index and mispredict flag, then one update cycle.
    task automatic resolve(input logic [31:0] pc, input logic jal, input logic tk,
                           input logic [31:0] tgt, input logic st);
        look(pc);
        upd_pc        = pc;
        upd_is_jal    = jal;
        upd_taken     = tk;
        upd_target    = tgt;
        upd_bht_idx_b = b_idx;
        upd_bht_idx_g = g_idx;
        upd_mispred_b = (b_taken != tk) || (tk && b_target != tgt);
        upd_mispred_g = (g_taken != tk) || (tk && g_target != tgt);
        stall         = st;
        upd_valid     = 1'b1;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        stall     = 1'b0;
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_is_jal = 1'b0;
        upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_bht_idx_b = '0; upd_bht_idx_g = '0; upd_mispred_b = 1'b0; upd_mispred_g = 1'b0;

        // Reset state
        do_reset();
        look(32'h60);
        check("rst_taken",  32'(b_taken), 32'd0);
        check("rst_target", b_target, 32'd0);
        check("rst_br",     32'(b_br), 32'd0);
        check("rst_mp",     32'(b_mp), 32'd0);
        check("rst_idx_b",  32'(b_idx), 32'h18);
        check("rst_idx_g",  32'(g_idx), 32'h18);

        // Bimodal bne hysteresis
        resolve(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        resolve(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        look(32'h100);
        check("bne_taken",  32'(b_taken), 32'd1);
        check("bne_target", b_target, 32'h80);
        resolve(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        check("bne_nt1_taken", 32'(b_taken), 32'd1);
        resolve(32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        look(32'h100);
        check("bne_nt2_taken", 32'(b_taken), 32'd0);

        // jal ignores the BHT
        resolve(32'h200, 1'b1, 1'b1, 32'h400, 1'b0);
        look(32'h200);
        check("jal_taken",  32'(b_taken), 32'd1);
        check("jal_target", b_target, 32'h400);
        check("jal_br",     32'(b_br), 32'd5);
        check("jal_mp",     32'(b_mp), 32'd4);

        // Stalled update is dropped
        resolve(32'h500, 1'b0, 1'b1, 32'h600, 1'b1);
        look(32'h500);
        check("stall_taken", 32'(b_taken), 32'd0);
        check("stall_br",    32'(b_br), 32'd5);

        // 0x100 and 0x200 share a BTB slot
        resolve(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        look(32'h100);
        check("alias_a_taken",  32'(b_taken), 32'd1);
        check("alias_a_target", b_target, 32'h80);
        resolve(32'h200, 1'b1, 1'b1, 32'h400, 1'b0);
        look(32'h100);
        check("evict_taken",  32'(b_taken), 32'd0);
        check("evict_target", b_target, 32'd0);
        look(32'h200);
        check("evict_b_target", b_target, 32'h400);
        check("evict_br", 32'(b_br), 32'd7);
        check("evict_mp", 32'(b_mp), 32'd6);

        // gshare learns alternating loop branch after warm-up
        do_reset();
        for (int i = 0; i < 20; i++) begin
            look(32'h300);
            if (i >= 6) check($sformatf("gsh_pred_%0d", i), 32'(g_taken), 32'((i % 2) == 0));
            resolve(32'h300, 1'b0, 1'((i % 2) == 0), 32'h340, 1'b0);
            if (i == 6) check("gsh_mp_warm", g_mp, 32'd3);
        end
        check("gsh_br", g_br, 32'd20);
        check("gsh_mp", g_mp, 32'd3);

        // Counter wrap and reset priority over update
        do_reset();
        for (int i = 0; i < 17; i++) resolve(32'h700, 1'b0, 1'b0, 32'h0, 1'b0);
        check("wrap_br", 32'(b_br), 32'd1);
        check("wrap_mp", 32'(b_mp), 32'd0);
        check("wrap_g_br", g_br, 32'd17);
        resolve(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        resolve(32'h100, 1'b0, 1'b1, 32'h80, 1'b0);
        look(32'h100);
        check("pre_rst_taken", 32'(b_taken), 32'd1);
        @(negedge clk);
        rst = 1'b1; upd_valid = 1'b1; upd_pc = 32'h100; upd_is_jal = 1'b0;
        upd_taken = 1'b1; upd_target = 32'h80; upd_mispred_b = 1'b1; upd_mispred_g = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; upd_valid = 1'b0;
        look(32'h100);
        check("rstupd_taken",  32'(b_taken), 32'd0);
        check("rstupd_target", b_target, 32'd0);
        check("rstupd_br",     32'(b_br), 32'd0);
        check("rstupd_mp",     32'(b_mp), 32'd0);
        check("rstupd_g_br",   g_br, 32'd0);
        check("rstupd_g_idx",  32'(g_idx), 32'h40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
